// File: rtl/pwm.sv
// Fixed-frequency 11-bit PWM: 2048-clock frame, output high for duty_q clocks
// at the start of each frame, duty shadowed only at the frame boundary.
module pwm (
  input  logic        clk,
  input  logic        rst_n,      // synchronous, active-high despite the name
  input  logic [10:0] duty,
  output logic        PWM_sig,
  output logic        PWM_synch
);

  localparam logic [10:0] CNT_LAST = 11'h7FF;

  logic [10:0] cnt_r;
  logic [10:0] duty_q_r;
  logic        pwm_sig_r;
  logic        last_s;

  // Decode the final cycle of the frame from registered state only.
  always_comb begin
    last_s = 1'b0;
    if (cnt_r == CNT_LAST) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // Free-running frame counter; wraps 2047 -> 0 with no stall.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_r <= 11'd0;
    end else begin
      cnt_r <= cnt_r + 11'd1;
    end
  end

  // Shadow duty: tracks the input while in reset, otherwise reloads only on
  // the last cycle of a frame so mid-frame changes never truncate a pulse.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      duty_q_r <= duty;
    end else if (last_s) begin
      duty_q_r <= duty;
    end else begin
      duty_q_r <= duty_q_r;
    end
  end

  // Registered PWM output; on the last cycle cnt_r is 2047, which can never
  // be below an 11-bit duty, so every frame ends with at least one low clock.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pwm_sig_r <= 1'b0;
    end else begin
      pwm_sig_r <= (cnt_r < duty_q_r);
    end
  end

  assign PWM_sig   = pwm_sig_r;
  assign PWM_synch = last_s;

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm: directed scenarios plus randomized duty and
// reset activity, compared every cycle against a frame-level reference model.
module tb_pwm;

  logic        clk;
  logic        rst_n;
  logic [10:0] duty;
  logic        PWM_sig;
  logic        PWM_synch;

  int vectors;
  int miscompares;

  // Reference model state: edges since release and the duty owned by each frame.
  int k;
  int frame_duty[int];
  logic exp_sig;
  logic exp_synch;

  pwm dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .duty      (duty),
    .PWM_sig   (PWM_sig),
    .PWM_synch (PWM_synch)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Frame-level model: edge number k (1-based after release) sits at position
  // (k-1) mod 2048 of frame (k-1)/2048; the output is high for the first
  // frame_duty[frame] positions. Duty present at a frame's last edge owns the next frame.
  task automatic model_edge(input logic r, input logic [10:0] d);
    int pos;
    int frame;
    if (r) begin
      k = 0;
      frame_duty.delete();
      frame_duty[0] = int'(d);
      exp_sig   = 1'b0;
      exp_synch = 1'b0;
    end else begin
      k++;
      pos   = (k - 1) % 2048;
      frame = (k - 1) / 2048;
      if (pos == 2047) frame_duty[frame + 1] = int'(d);
      exp_sig   = (pos < frame_duty[frame]);
      exp_synch = ((k % 2048) == 2047);
    end
  endtask

  // One clock: snapshot inputs the DUT will sample, advance, then compare.
  task automatic step();
    logic r;
    logic [10:0] d;
    r = rst_n;
    d = duty;
    @(posedge clk);
    #1;
    model_edge(r, d);
    check_eq("pwm_sig", {31'd0, PWM_sig}, {31'd0, exp_sig});
    check_eq("pwm_synch", {31'd0, PWM_synch}, {31'd0, exp_synch});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset(input int cycles, input logic [10:0] d);
    rst_n = 1'b1;
    duty  = d;
    run(cycles);
    rst_n = 1'b0;
  endtask

  // Run n cycles and return how many of them had PWM_sig high.
  task automatic run_count(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (PWM_sig) highs++;
    end
  endtask

  initial begin
    int highs;
    int rnd;
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    exp_sig     = 1'b0;
    exp_synch   = 1'b0;
    rst_n       = 1'b1;
    duty        = 11'd1028;

    // Duty 1028: one reset edge, then 5000 clocks; first frame high time measured.
    do_reset(1, 11'd1028);
    run_count(2048, highs);
    check_eq("high_1028", highs, 1028);
    run(5000 - 2048);

    // Reset is synchronous: raising it mid-cycle must not touch the output.
    check_eq("pre_async_sig", {31'd0, PWM_sig}, {31'd0, exp_sig});
    rst_n = 1'b1;
    #2;
    check_eq("async_immune", {31'd0, PWM_sig}, {31'd0, exp_sig});
    duty = 11'd512;
    run(4);
    rst_n = 1'b0;
    run_count(2048, highs);
    check_eq("high_512", highs, 512);
    run(1000);

    // Mid-run reset to 256.
    do_reset(3, 11'd256);
    run_count(2048, highs);
    check_eq("high_256", highs, 256);

    // Extremes: duty 0 never high, duty 2047 low once per frame.
    do_reset(2, 11'd0);
    run_count(4200, highs);
    check_eq("high_0", highs, 0);
    do_reset(2, 11'd2047);
    run_count(4096, highs);
    check_eq("low_2047", 4096 - highs, 2);

    // Mid-period change at cnt = 500: current frame keeps 1028, next gets 300.
    do_reset(1, 11'd1028);
    run(500);
    duty = 11'd300;
    run_count(2048 - 500, highs);
    check_eq("midchg_cur", highs, 1028 - 500);
    run_count(2048, highs);
    check_eq("midchg_next", highs, 300);

    // Change exactly in the cnt = 2047 cycle, then move duty away again.
    duty = 11'd700;
    while ((k % 2048) != 2047) step();
    duty = 11'd1500;
    step();
    duty = 11'd20;
    run_count(2048, highs);
    check_eq("boundary_chg", highs, 1500);

    // Randomized duty changes with occasional resets.
    for (int it = 0; it < 10; it++) begin
      duty = 11'($urandom_range(0, 2047));
      run($urandom_range(50, 4000));
      rnd = $urandom_range(0, 3);
      if (rnd == 0) do_reset($urandom_range(1, 4), 11'($urandom_range(0, 2047)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
